instr_loader: RTL

Boot-time program loader that writes the instruction memory the processor fetches from. It takes a byte stream from an external link over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive word addresses through the instruction memory's write port and checks a trailing checksum. It holds the processor in reset (`cpu_rst`) until a complete, checksum-correct image has been loaded.

---
 rtl/instr_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to instruction
// memory and releases the processor from reset once the trailing checksum matches.
module instr_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error,
  output logic [2:0]            dbg_state
);

  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_shift;
  logic [31:0]     r_count;
  logic [31:0]     r_csum;
  logic [IW-1:0]   r_index;

  logic            w_accept;
  logic            w_word_done;
  logic            w_last_word;
  logic [31:0]     w_word;

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; the sender keeps
  // rx_data stable while rx_valid is high, and rx_ready never depends on rx_valid.
  assign w_accept    = rx_valid && rx_ready;
  assign w_word      = {r_shift, rx_data};
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
  assign w_last_word = (32'(r_index) + 32'd1) == r_count;
  assign dbg_state   = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_word_done) begin
          if (w_word > 32'(MAX_WORDS)) w_state_nxt = S_ERROR;
          else if (w_word == 32'd0)    w_state_nxt = S_CSUM;
          else                         w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_word_done && w_last_word) w_state_nxt = S_CSUM;
      S_CSUM: if (w_word_done) w_state_nxt = (w_word == r_csum) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (restart) w_state_nxt = S_HDR;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_INIT;
      r_byte_cnt     <= 2'd0;
      r_shift        <= 24'd0;
      r_count        <= 32'd0;
      r_csum         <= 32'd0;
      r_index        <= '0;
      rx_ready       <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= ADDR_WIDTH'(BASE_ADDR);
      mem_write_data <= 32'd0;
      cpu_rst        <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      rx_ready     <= (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) ||
                      (w_state_nxt == S_CSUM);
      cpu_rst      <= (w_state_nxt != S_DONE);
      load_done    <= (w_state_nxt == S_DONE);
      load_error   <= (w_state_nxt == S_ERROR);
      mem_write_en <= 1'b0;

      if (w_accept) begin
        r_shift    <= w_word[23:0];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_state_nxt != r_state) r_byte_cnt <= 2'd0;

      case (r_state)
        S_HDR: if (w_word_done) r_count <= w_word;
        S_DATA: begin
          if (w_word_done) begin
            mem_write_en   <= 1'b1;
            mem_write_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({r_index, 2'b00});
            mem_write_data <= w_word;
            r_index        <= r_index + 1'b1;
            r_csum         <= r_csum + w_word;
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            r_index <= '0;
            r_csum  <= 32'd0;
            r_count <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
